// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
// The optional lock/burst mode is selected with DMEM_ARB_LOCK_EN.
package dmem_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int NPORT  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } dmem_arb_state_e;

    typedef logic [$clog2(NPORT)-1:0] port_idx_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dmem_cmd_t;

    // With two requesters the "other" port is simply the complement.
    function automatic port_idx_t other_port(input port_idx_t p);
        return port_idx_t'(~p);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin winner select for dmem_arbiter.
// With DMEM_ARB_LOCK_EN the last-granted port may keep the grant while it
// holds lock, bounded by LOCK_MAX consecutive locked wins against a waiting
// port; the bounding counter lives here.
module rr_pick2 import dmem_arb_pkg::*;
`ifdef DMEM_ARB_LOCK_EN
#(
    parameter int LOCK_MAX = 4
)
`endif
(
`ifdef DMEM_ARB_LOCK_EN
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pick_en,
    input  logic [NPORT-1:0] lock,
`endif
    input  logic [NPORT-1:0] req,
    input  port_idx_t        last_gnt,
    output port_idx_t        win
);

    logic      both_s;
    port_idx_t rr_win_s;

    // Plain round-robin: a lone requester wins, a tie goes to the port not granted last.
    always_comb begin
        both_s = req[0] & req[1];
        if (both_s) begin
            rr_win_s = other_port(last_gnt);
        end else if (req[1]) begin
            rr_win_s = port_idx_t'(1'b1);
        end else begin
            rr_win_s = port_idx_t'(1'b0);
        end
    end

`ifdef DMEM_ARB_LOCK_EN
    localparam int                CNT_W      = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

    logic [CNT_W-1:0] lock_cnt_r;
    logic [CNT_W-1:0] lock_cnt_s;
    logic             lock_hold_s;

    // Locked win for the last-granted port until it has starved the other port LOCK_MAX times.
    always_comb begin
        lock_hold_s = both_s && lock[last_gnt] && (lock_cnt_r < LOCK_MAX_C);
        lock_cnt_s  = lock_cnt_r;
        if (lock_hold_s) begin
            win = last_gnt;
        end else begin
            win = rr_win_s;
        end
        if (pick_en && (|req)) begin
            if (lock_hold_s) begin
                lock_cnt_s = lock_cnt_r + CNT_W'(1);
            end else begin
                lock_cnt_s = '0;
            end
        end else begin
            lock_cnt_s = lock_cnt_r;
        end
    end

    // Consecutive locked-win counter, advanced only when a grant is actually made.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_r <= '0;
        end else begin
            lock_cnt_r <= lock_cnt_s;
        end
    end
`else
    // Without lock support the round-robin choice is final.
    always_comb begin
        win = rr_win_s;
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port 256x8 data memory between the core
// LSU (port 0) and the host/debug loader (port 1). One access every two
// cycles: IDLE picks and latches a command, ISSUE strobes the memory for one
// cycle. Optional lock/burst mode: define DMEM_ARB_LOCK_EN (adds lock0/lock1
// and the LOCK_MAX parameter).
module dmem_arbiter import dmem_arb_pkg::*;
`ifdef DMEM_ARB_LOCK_EN
#(
    parameter int LOCK_MAX = 4
)
`endif
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
`ifdef DMEM_ARB_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    dmem_arb_state_e   state_r, state_s;
    dmem_cmd_t         cmd_r, cmd_s, cmd0_s, cmd1_s;
    port_idx_t         port_r, port_s, last_r, last_s, win_s;
    logic [NPORT-1:0]  req_s, gnt_r, gnt_s, rvalid_r, rvalid_s;
    logic              mem_read_r, mem_read_s, mem_write_r, mem_write_s;
    logic [DATA_W-1:0] rdata0_r, rdata0_s, rdata1_r, rdata1_s;

    assign req_s  = {req1, req0};
    assign cmd0_s = {we0, addr0, wdata0};
    assign cmd1_s = {we1, addr1, wdata1};

`ifdef DMEM_ARB_LOCK_EN
    logic pick_en_s;
    assign pick_en_s = (state_r == IDLE);

    rr_pick2 #(
        .LOCK_MAX (LOCK_MAX)
    ) u_pick (
        .clk      (clk),
        .rst_n    (rst_n),
        .pick_en  (pick_en_s),
        .lock     ({lock1, lock0}),
        .req      (req_s),
        .last_gnt (last_r),
        .win      (win_s)
    );
`else
    rr_pick2 u_pick (
        .req      (req_s),
        .last_gnt (last_r),
        .win      (win_s)
    );
`endif

    // Next state and next values of every registered output.
    always_comb begin
        state_s     = state_r;
        cmd_s       = cmd_r;
        port_s      = port_r;
        last_s      = last_r;
        gnt_s       = '0;
        rvalid_s    = '0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        rdata0_s    = rdata0_r;
        rdata1_s    = rdata1_r;
        case (state_r)
            IDLE: begin
                if (|req_s) begin
                    state_s        = ISSUE;
                    cmd_s          = (win_s == port_idx_t'(1'b1)) ? cmd1_s : cmd0_s;
                    port_s         = win_s;
                    last_s         = win_s;
                    gnt_s[win_s]   = 1'b1;
                    mem_write_s    = cmd_s.we;
                    mem_read_s     = ~cmd_s.we;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                // Read data is captured as the strobe ends; writes commit at this same edge.
                state_s = IDLE;
                if (mem_read_r) begin
                    rvalid_s[port_r] = 1'b1;
                    if (port_r == port_idx_t'(1'b0)) begin
                        rdata0_s = mem_rdata;
                    end else begin
                        rdata1_s = mem_rdata;
                    end
                end else begin
                    rvalid_s = '0;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, latched command and output registers; reset drops strobes immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cmd_r       <= '0;
            port_r      <= port_idx_t'(1'b0);
            last_r      <= port_idx_t'(1'b1);
            gnt_r       <= '0;
            rvalid_r    <= '0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            rdata0_r    <= '0;
            rdata1_r    <= '0;
        end else begin
            state_r     <= state_s;
            cmd_r       <= cmd_s;
            port_r      <= port_s;
            last_r      <= last_s;
            gnt_r       <= gnt_s;
            rvalid_r    <= rvalid_s;
            mem_read_r  <= mem_read_s;
            mem_write_r <= mem_write_s;
            rdata0_r    <= rdata0_s;
            rdata1_r    <= rdata1_s;
        end
    end

    assign gnt0      = gnt_r[0];
    assign gnt1      = gnt_r[1];
    assign rvalid0   = rvalid_r[0];
    assign rvalid1   = rvalid_r[1];
    assign rdata0    = rdata0_r;
    assign rdata1    = rdata1_r;
    assign mem_addr  = cmd_r.addr;
    assign mem_wdata = cmd_r.wdata;
    assign mem_read  = mem_read_r;
    assign mem_write = mem_write_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed, table-driven bench for dmem_arbiter with a
// behavioural 256x8 memory. Lock-mode sequence only with DMEM_ARB_LOCK_EN.
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = 8'h00, wdata0 = 8'h00, addr1 = 8'h00, wdata1 = 8'h00;
`ifdef DMEM_ARB_LOCK_EN
    logic       lock0 = 1'b0, lock1 = 1'b0;
`endif
    logic       gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write;
    logic [7:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    logic [7:0] mem [256];
    logic       init_en = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
`ifdef DMEM_ARB_LOCK_EN
        .lock0     (lock0),
        .lock1     (lock1),
`endif
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: preload pattern addr+0x50, synchronous write, combinational read.
    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) + 8'h50;
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // 0xEE stands in for the floating bus so a stray capture is visible.
    assign mem_rdata = mem_read ? mem[mem_addr] : 8'hEE;

    typedef struct {
        logic        r0, w0;
        logic [7:0]  a0, d0;
        logic        r1, w1;
        logic [7:0]  a1, d1;
        logic [37:0] exp;
    } vec_t;

    vec_t vecs[$];

    // flags = {gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write}
    function automatic vec_t mk(input logic r0, w0, input logic [7:0] a0, d0,
                                input logic r1, w1, input logic [7:0] a1, d1,
                                input logic [5:0] flags,
                                input logic [7:0] rd0, rd1, ma, mw);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.exp = {flags, rd0, rd1, ma, mw};
        return v;
    endfunction

    function automatic logic [37:0] outs();
        return {gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write, rdata0, rdata1, mem_addr, mem_wdata};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
        req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 1'b0; we0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Tie-break after reset: strict 0,1,0,1,0,1 alternation, every port served every 4 cycles.
        vecs.push_back(mk(1,0,8'h20,8'h00, 1,0,8'h30,8'h00, 6'b100010, 8'h00,8'h00,8'h20,8'h00));
        vecs.push_back(mk(1,0,8'h21,8'h00, 1,0,8'h30,8'h00, 6'b001000, 8'h70,8'h00,8'h20,8'h00));
        vecs.push_back(mk(1,0,8'h21,8'h00, 1,0,8'h30,8'h00, 6'b010010, 8'h70,8'h00,8'h30,8'h00));
        vecs.push_back(mk(1,0,8'h21,8'h00, 1,0,8'h31,8'h00, 6'b000100, 8'h70,8'h80,8'h30,8'h00));
        vecs.push_back(mk(1,0,8'h21,8'h00, 1,0,8'h31,8'h00, 6'b100010, 8'h70,8'h80,8'h21,8'h00));
        vecs.push_back(mk(1,0,8'h22,8'h00, 1,0,8'h31,8'h00, 6'b001000, 8'h71,8'h80,8'h21,8'h00));
        vecs.push_back(mk(1,0,8'h22,8'h00, 1,0,8'h31,8'h00, 6'b010010, 8'h71,8'h80,8'h31,8'h00));
        vecs.push_back(mk(1,0,8'h22,8'h00, 1,0,8'h32,8'h00, 6'b000100, 8'h71,8'h81,8'h31,8'h00));
        vecs.push_back(mk(1,0,8'h22,8'h00, 1,0,8'h32,8'h00, 6'b100010, 8'h71,8'h81,8'h22,8'h00));
        vecs.push_back(mk(0,0,8'h00,8'h00, 1,0,8'h32,8'h00, 6'b001000, 8'h72,8'h81,8'h22,8'h00));
        vecs.push_back(mk(0,0,8'h00,8'h00, 1,0,8'h32,8'h00, 6'b010010, 8'h72,8'h81,8'h32,8'h00));
        vecs.push_back(mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 6'b000100, 8'h72,8'h82,8'h32,8'h00));
        // Port 0 writes 0xA5 to 0x10 then reads it back; the write gives no rvalid.
        vecs.push_back(mk(1,1,8'h10,8'hA5, 0,0,8'h00,8'h00, 6'b100001, 8'h72,8'h82,8'h10,8'hA5));
        vecs.push_back(mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 6'b000000, 8'h72,8'h82,8'h10,8'hA5));
        vecs.push_back(mk(1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 6'b100010, 8'h72,8'h82,8'h10,8'h00));
        vecs.push_back(mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 6'b001000, 8'hA5,8'h82,8'h10,8'h00));
        vecs.push_back(mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 6'b000000, 8'hA5,8'h82,8'h10,8'h00));
        // Port 1 alone: back-to-back reads of 0x00..0x04, one grant every 2 cycles.
        vecs.push_back(mk(0,0,8'h00,8'h00, 1,0,8'h00,8'h00, 6'b010010, 8'hA5,8'h82,8'h00,8'h00));
        vecs.push_back(mk(0,0,8'h00,8'h00, 1,0,8'h01,8'h00, 6'b000100, 8'hA5,8'h50,8'h00,8'h00));
        vecs.push_back(mk(0,0,8'h00,8'h00, 1,0,8'h01,8'h00, 6'b010010, 8'hA5,8'h50,8'h01,8'h00));
        vecs.push_back(mk(0,0,8'h00,8'h00, 1,0,8'h02,8'h00, 6'b000100, 8'hA5,8'h51,8'h01,8'h00));
        vecs.push_back(mk(0,0,8'h00,8'h00, 1,0,8'h02,8'h00, 6'b010010, 8'hA5,8'h51,8'h02,8'h00));
        vecs.push_back(mk(0,0,8'h00,8'h00, 1,0,8'h03,8'h00, 6'b000100, 8'hA5,8'h52,8'h02,8'h00));
        vecs.push_back(mk(0,0,8'h00,8'h00, 1,0,8'h03,8'h00, 6'b010010, 8'hA5,8'h52,8'h03,8'h00));
        vecs.push_back(mk(0,0,8'h00,8'h00, 1,0,8'h04,8'h00, 6'b000100, 8'hA5,8'h53,8'h03,8'h00));
        vecs.push_back(mk(0,0,8'h00,8'h00, 1,0,8'h04,8'h00, 6'b010010, 8'hA5,8'h53,8'h04,8'h00));
        vecs.push_back(mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 6'b000100, 8'hA5,8'h54,8'h04,8'h00));
        vecs.push_back(mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 6'b000000, 8'hA5,8'h54,8'h04,8'h00));

        // Reset (also preloads memory).
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        init_en = 1'b0;
        #1;
        check("reset_values", 64'(outs()), 64'd0);

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), 64'(outs()), 64'(vecs[i].exp));
        end

        // Reset while a port-0 read is in ISSUE: strobe drops at once, no rvalid follows.
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h20; wdata0 = 8'h00;
        @(posedge clk);
        #1;
        check("rd_issue_strobe", 64'({gnt0, mem_read}), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("rd_reset_async_clear", 64'(outs()), 64'd0);
        req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("rd_reset_no_rvalid%0d", k), 64'({gnt0, rvalid0, mem_read}), 64'd0);
        end

        // Reset while a write is in ISSUE: the write is aborted, memory keeps its old value.
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h40; wdata0 = 8'h99;
        @(posedge clk);
        #1;
        check("wr_issue_strobe", 64'(mem_write), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("wr_reset_strobe_drop", 64'(mem_write), 64'd0);
        req0 = 1'b0; we0 = 1'b0; wdata0 = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        req0 = 1'b1;
        @(posedge clk);
        #1;
        check("wr_abort_read_gnt", 64'(gnt0), 64'd1);
        req0 = 1'b0;
        @(posedge clk);
        #1;
        check("wr_abort_readback", 64'({rvalid0, rdata0}), 64'({1'b1, 8'h90}));

`ifdef DMEM_ARB_LOCK_EN
        // Locked port 0 against continuously requesting port 1: 0,0,0,0,0,1 repeating.
        begin
            logic [11:0] got;
            int          ng;
            got = '0;
            ng  = 0;
            do_reset();
            lock0 = 1'b1;
            req0 = 1'b1; addr0 = 8'h05;
            req1 = 1'b1; addr1 = 8'h06;
            for (int c = 0; c < 60 && ng < 12; c++) begin
                @(posedge clk);
                #1;
                if (gnt0 | gnt1) begin
                    got[ng] = gnt1;
                    ng++;
                end
            end
            check("lock_grant_count", 64'(ng), 64'd12);
            for (int k = 0; k < 12; k++) begin
                check($sformatf("lock_grant%0d", k), 64'(got[k]), 64'((k == 5) || (k == 11)));
            end
            req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
